// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of a combinational-read data memory.
// Checks each request, runs exactly one ACCESS cycle for legal ones, and returns data or a fault.
module lsu_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_SIZE   = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] fault_addr,
   output logic                  mem_wr_en,
   output logic [2:0]            mem_funct3,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_SIZE * 4);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [2:0]              funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
   logic                    resp_err_q, resp_err_d;
   logic [ADDR_WIDTH-1:0]   fault_addr_q, fault_addr_d;
   logic                    req_illegal;

   always_comb begin
      req_illegal = 1'b0;
      case (req_funct3)
         3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
         3'b100:                 req_illegal = req_we;
         3'b001:                 req_illegal = req_addr[0];
         3'b101:                 req_illegal = req_we | req_addr[0];
         3'b010:                 req_illegal = (req_addr[1:0] != 2'b00);
         default:                req_illegal = 1'b0;
      endcase
      if (req_addr >= ADDR_LIMIT) begin
         req_illegal = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      fault_addr_d = fault_addr_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (req_illegal) begin
                  resp_err_d   = 1'b1;
                  resp_data_d  = '0;
                  fault_addr_d = req_addr;
                  state_d      = S_RESP;
               end else begin
                  state_d = S_ACCESS;
               end
            end
         end
         S_ACCESS: begin
            resp_err_d  = 1'b0;
            resp_data_d = we_q ? '0 : mem_rd_data;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         funct3_q     <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   // Gating with reset keeps a store from committing on the same edge that aborts it.
   assign mem_wr_en   = (state_q == S_ACCESS) & we_q & ~reset;
   assign req_ready   = (state_q == S_IDLE);
   assign resp_valid  = (state_q == S_RESP);
   assign resp_data   = resp_data_q;
   assign resp_err    = resp_err_q;
   assign fault_addr  = fault_addr_q;
   assign mem_funct3  = funct3_q;
   assign mem_addr    = addr_q;
   assign mem_wr_data = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios then random traffic against a byte-array memory model.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        reset, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
   logic [2:0]  req_funct3, mem_funct3;
   logic [31:0] req_addr, req_wdata, resp_data, fault_addr, mem_addr, mem_wr_data, mem_rd_data;
   logic        mem_wr_en;
   logic        mem_clear;

   int n_assert = 0;
   int n_fail = 0;
   int wr_pulses = 0;

   logic [31:0] dmem [0:63];
   logic [7:0]  ref_mem [0:255];
   logic [31:0] exp_fault;

   lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(64)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_err(resp_err), .fault_addr(fault_addr),
      .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   // Data memory attached to the DUT: combinational extending read, byte-lane write on the edge.
   always_comb begin
      logic [31:0] word;
      logic [31:0] sh;
      word = dmem[mem_addr[7:2]];
      sh   = {27'd0, mem_addr[1:0], 3'b000};
      word = word >> sh;
      mem_rd_data = word;
      case (mem_funct3)
         3'b000:  mem_rd_data = {{24{word[7]}}, word[7:0]};
         3'b001:  mem_rd_data = {{16{word[15]}}, word[15:0]};
         3'b100:  mem_rd_data = {24'd0, word[7:0]};
         3'b101:  mem_rd_data = {16'd0, word[15:0]};
         default: mem_rd_data = word;
      endcase
   end

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < 64; i++) dmem[i] <= '0;
      end else if (mem_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if ((mem_funct3 == 3'b010) ||
                (mem_funct3 == 3'b001 && (b >> 1) == int'(mem_addr[1])) ||
                (mem_funct3 == 3'b000 && b == int'(mem_addr[1:0])))
               dmem[mem_addr[7:2]][b*8 +: 8] <= mem_wr_data[((b - int'(mem_addr[1:0])) & 3)*8 +: 8];
         end
      end
   end

   always @(posedge clk) if (mem_wr_en) wr_pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_illegal(input bit we, input int f3, input int addr);
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
      if (we && (f3 == 4 || f3 == 5)) return 1;
      if ((f3 == 1 || f3 == 5) && (addr % 2) != 0) return 1;
      if (f3 == 2 && (addr % 4) != 0) return 1;
      if (addr >= 64 * 4) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] ref_load(input int f3, input int addr);
      int v;
      case (f3)
         0: begin v = ref_mem[addr]; if (v >= 128) v -= 256; end
         1: begin v = ref_mem[addr] + 256 * ref_mem[addr+1]; if (v >= 32768) v -= 65536; end
         4: v = ref_mem[addr];
         5: v = ref_mem[addr] + 256 * ref_mem[addr+1];
         default: v = {ref_mem[addr+3], ref_mem[addr+2], ref_mem[addr+1], ref_mem[addr]};
      endcase
      return 32'(v);
   endfunction

   function automatic int ref_size(input int f3);
      return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
   endfunction

   task automatic do_req(input bit we, input int f3, input int addr, input logic [31:0] wdata,
                         input int hold);
      bit          illegal;
      logic [31:0] exp_data;
      int          pulses0;
      illegal  = ref_illegal(we, f3, addr);
      exp_data = (illegal || we) ? 32'd0 : ref_load(f3, addr);
      check("req_ready_idle", req_ready, 1);
      req_valid = 1; req_we = we; req_funct3 = 3'(f3); req_addr = 32'(addr); req_wdata = wdata;
      pulses0 = wr_pulses;
      @(posedge clk); #1;
      req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
      if (!illegal) begin
         check("access_no_valid", resp_valid, 0);
         check("access_wr_en", mem_wr_en, we);
         check("access_addr", mem_addr, addr);
         @(posedge clk); #1;
      end
      check("resp_valid", resp_valid, 1);
      check("resp_err", resp_err, illegal);
      check("resp_data", resp_data, exp_data);
      if (illegal) exp_fault = 32'(addr);
      check("fault_addr", fault_addr, exp_fault);
      for (int h = 0; h < hold; h++) begin
         req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h0;
         @(posedge clk); #1;
         check("hold_valid", resp_valid, 1);
         check("hold_data", resp_data, exp_data);
         check("hold_req_ready", req_ready, 0);
         check("hold_wr_en", mem_wr_en, 0);
      end
      req_valid = 0; resp_ready = 1;
      @(posedge clk); #1;
      resp_ready = 0;
      check("after_hs_valid", resp_valid, 0);
      check("after_hs_ready", req_ready, 1);
      check("mem_addr_held", mem_addr, addr);
      check("wr_pulses", 32'(wr_pulses - pulses0), (we && !illegal) ? 1 : 0);
      if (we && !illegal)
         for (int b = 0; b < ref_size(f3); b++) ref_mem[addr + b] = wdata[b*8 +: 8];
      $display("txn we=%0d f3=%0d addr=0x%0h wdata=0x%08h -> err=%0d data=0x%08h",
               we, f3, addr, wdata, resp_err, resp_data);
   endtask

   initial begin
      int a;
      logic [31:0] w;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
      exp_fault = 32'd0;
      reset = 1; mem_clear = 1; req_valid = 0; req_we = 0; req_funct3 = 0;
      req_addr = 0; req_wdata = 0; resp_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      reset = 0; mem_clear = 0;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_fault_addr", fault_addr, 0);
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wr_data, 0);

      do_req(1, 2, 'h10, 32'hDEADBEEF, 0);
      do_req(0, 2, 'h10, 32'h0, 0);
      do_req(1, 0, 'h13, 32'hABCDEF80, 0);
      do_req(0, 0, 'h13, 32'h0, 0);
      do_req(0, 4, 'h13, 32'h0, 0);
      do_req(0, 2, 'h12, 32'h0, 0);
      do_req(1, 1, 'h101, 32'h1234, 0);
      do_req(0, 2, 'h10, 32'h0, 5);

      // Store aborted by reset in its ACCESS cycle.
      check("req_ready_idle", req_ready, 1);
      req_valid = 1; req_we = 1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      a = wr_pulses;
      @(posedge clk); #1;
      req_valid = 0;
      check("abort_wr_en_pre", mem_wr_en, 1);
      reset = 1;
      #1;
      check("abort_wr_en_rst", mem_wr_en, 0);
      @(posedge clk); #1;
      reset = 0;
      exp_fault = 32'd0;
      check("abort_resp_valid", resp_valid, 0);
      check("abort_req_ready", req_ready, 1);
      check("abort_fault_addr", fault_addr, 0);
      check("abort_pulses", 32'(wr_pulses - a), 0);
      w = {ref_mem[8'h23], ref_mem[8'h22], ref_mem[8'h21], ref_mem[8'h20]};
      check("abort_mem_word", dmem[8], w);
      $display("txn reset during store ACCESS addr=0x20 -> mem=0x%08h", dmem[8]);

      do_req(0, 3, 'h20, 32'h0, 0);
      do_req(1, 4, 'h24, 32'h55, 1);
      do_req(0, 2, 'h10, 32'h0, 0);

      for (int t = 0; t < 60; t++) begin
         a = $urandom_range(0, 271);
         if ($urandom_range(0, 1) == 1) a = a & ~3;
         do_req(1'($urandom_range(0, 1)), $urandom_range(0, 7), a, $urandom, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
